// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//  8N1 UART receiver, LSB first. The asynchronous serial_in pin is brought into
//  the clk domain by a two-flop synchroniser. Each bit is sampled at its centre
//  and the stop bit is checked. Each byte is then offered on a ready/valid
//  output that is backed by a one-entry holding buffer.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | line idle, waiting for rx to fall
//  START | confirming the start bit at its centre (a high rx is a glitch)
//  DATA  | sampling 8 data bits, LSB first
//  STOP  | sampling the stop bit, then delivering the byte or flagging an error
//
// Ports
//  clk             in   1  core clock, rising edge
//  rst             in   1  synchronous, active-high reset
//  serial_in       in   1  asynchronous UART line, idle high
//  data_out        out  8  received byte, stable while data_out_valid=1
//  data_out_valid  out  1  holding buffer occupied
//  data_out_ready  in   1  consumer accepts (fire = valid & ready)
//  framing_error   out  1  one-cycle pulse, stop bit sampled low
//  overrun         out  1  one-cycle pulse, byte dropped because buffer full
// -----------------------------------------------------------------------------
module uart_receiver #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int T  = CLOCK_FREQ / BAUD_RATE;
   localparam int S  = T / 2;
   localparam int CW = $clog2(T);

   localparam logic [CW-1:0] C_LAST   = CW'(T - 1);
   localparam logic [CW-1:0] C_SAMPLE = CW'(S);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic          r_sync1;
   logic          r_sync2;
   logic [1:0]    r_state;
   logic [CW-1:0] r_clk_cnt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_framing_error;
   logic          r_overrun;

   logic w_rx;
   logic w_sample;
   logic w_fire;
   logic w_finish;
   logic w_good;

   assign w_rx     = r_sync2;
   assign w_sample = (r_state != IDLE) && (r_clk_cnt == C_SAMPLE);
   assign w_fire   = r_valid & data_out_ready;
   assign w_finish = (r_state == STOP) && w_sample;
   assign w_good   = w_finish & w_rx;

   // Both flops reset high so that reset release cannot look like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= serial_in;
         r_sync2 <= r_sync1;
      end
   end

   // The counter is held at zero in IDLE, which also clears it on the IDLE->START
   // transition. From then on it free-runs modulo T, so every bit of the frame
   // lands on the same count S.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_cnt <= '0;
      end else if (r_state == IDLE) begin
         r_clk_cnt <= '0;
      end else if (r_clk_cnt == C_LAST) begin
         r_clk_cnt <= '0;
      end else begin
         r_clk_cnt <= r_clk_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_rx) begin
                  r_state <= START;
               end
            end
            START: begin
               if (w_sample) begin
                  if (w_rx) begin
                     r_state <= IDLE;
                  end else begin
                     r_state   <= DATA;
                     r_bit_cnt <= 3'd0;
                  end
               end
            end
            DATA: begin
               if (w_sample) begin
                  r_shift[r_bit_cnt] <= w_rx;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end
            end
            STOP: begin
               // Leave at the stop-bit centre, so that a start bit following
               // directly after the stop bit is not missed.
               if (w_sample) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A buffer that is draining in this same cycle counts as free, so a
   // simultaneous fire and load keeps valid high with the new byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data          <= 8'h00;
         r_valid         <= 1'b0;
         r_framing_error <= 1'b0;
         r_overrun       <= 1'b0;
      end else begin
         r_framing_error <= w_finish & ~w_rx;
         r_overrun       <= w_good & r_valid & ~data_out_ready;
         if (w_good && (!r_valid || w_fire)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (w_fire) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_out       = r_data;
   assign data_out_valid = r_valid;
   assign framing_error  = r_framing_error;
   assign overrun        = r_overrun;

endmodule
